key_idle_timer: RTL

- Parametrised inactivity timer for the digital-lock datapath; successor to the single-threshold key timer.
- Any key activity restarts the count. Prolonged inactivity raises a warning, then a sticky expiry flag, with a single-cycle expiry pulse.
- Adds a prescaler, runtime-programmable timeout and warning thresholds, enable/clear controls, one-shot or auto-rearm mode, and a saturating expiry counter.
- Feeds the lock FSM, which uses expiry to abandon partial code entry.

---
 rtl/key_timer_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/key_idle_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/key_timer_pkg.sv
// Shared definitions for the key inactivity timer: state encoding and defaults.
package key_timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    HALT = 2'd3
  } timer_state_e;

  // Reasonable power-on threshold for integrators that do not program one.
  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into count ticks; one tick every PRESCALE running cycles.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Restart wins; otherwise advance only while running, wrapping on the tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_idle_timer.sv
// Inactivity timer for the lock datapath: warns, then flags expiry after idle keys.
module key_idle_timer
  import key_timer_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned CW       = 32,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned EW       = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [N-1:0]       key,
  input  logic               clear,
  input  logic               auto_rearm,
  input  logic [CW-1:0]      timeout,
  input  logic [CW-1:0]      warn_at,
  output logic [CW-1:0]      count,
  output logic               warn,
  output logic               expired,
  output logic               expire_pulse,
  output logic [EW-1:0]      expire_count,
  output logic [STATE_W-1:0] state
);

  timer_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          warn_q, warn_d;
  logic          expired_q, expired_d;
  logic          pulse_q, pulse_d;
  logic [EW-1:0] ecount_q, ecount_d;

  logic          key_act;
  logic          counting;
  logic          restart;
  logic          tick;
  logic [CW:0]   cnt_inc;
  logic          hit;
  logic          no_timeout;
  logic [CW-1:0] cnt_next;

  assign key_act    = |key;
  assign counting   = (state_q == RUN) || (state_q == WARN);
  assign restart    = !enable || clear || key_act;
  assign no_timeout = (timeout == '0);
  // Extra bit keeps count+1 from wrapping before the threshold compare.
  assign cnt_inc    = {1'b0, count_q} + (CW+1)'(1);
  assign hit        = !no_timeout && (cnt_inc >= {1'b0, timeout});

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .run    (counting),
    .restart(restart),
    .tick   (tick)
  );

  // Next-state and output logic in priority order: enable, clear, key, tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    warn_d    = warn_q;
    expired_d = expired_q;
    pulse_d   = 1'b0;
    ecount_d  = ecount_q;
    cnt_next  = count_q;

    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
      warn_d  = 1'b0;
    end else if (clear) begin
      state_d   = RUN;
      count_d   = '0;
      warn_d    = 1'b0;
      expired_d = 1'b0;
      ecount_d  = '0;
    end else if (key_act) begin
      state_d   = RUN;
      count_d   = '0;
      warn_d    = 1'b0;
      expired_d = 1'b0;
    end else if (counting) begin
      if (tick && hit) begin
        pulse_d   = 1'b1;
        expired_d = 1'b1;
        warn_d    = 1'b0;
        ecount_d  = (ecount_q == '1) ? ecount_q : ecount_q + EW'(1);
        if (auto_rearm) begin
          count_d = '0;
          state_d = RUN;
        end else begin
          count_d = timeout;
          state_d = HALT;
        end
      end else begin
        if (tick) begin
          if (no_timeout && (count_q == '1)) cnt_next = count_q;
          else                               cnt_next = count_q + CW'(1);
        end
        count_d = cnt_next;
        // Thresholds are live, so the warning is re-evaluated every cycle.
        warn_d  = (cnt_next >= warn_at) && (no_timeout || (warn_at < timeout));
        state_d = warn_d ? WARN : RUN;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      warn_q    <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      ecount_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      warn_q    <= warn_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      ecount_q  <= ecount_d;
    end
  end

  assign count        = count_q;
  assign warn         = warn_q;
  assign expired      = expired_q;
  assign expire_pulse = pulse_q;
  assign expire_count = ecount_q;
  assign state        = state_q;

endmodule
